// File: rtl/ifd_pkg.sv
// Shared types and field positions for the instruction fetch/decode stage.
// The HALT state exists only when IFD_HALT_EN is defined.
package ifd_pkg;

`ifdef IFD_HALT_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_HOLD, S_HALT} ifd_state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_HOLD} ifd_state_e;
`endif

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int RS_MSB   = 25;
  localparam int RS_LSB   = 21;
  localparam int RT_MSB   = 20;
  localparam int RT_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_HALT  = 6'b111111;

  typedef struct packed {
    logic [5:0]  opc;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
  } ifd_fields_t;

  function automatic logic is_halt(input logic [5:0] op);
    return op == OPC_HALT;
  endfunction

endpackage

// File: rtl/ifd_field_split.sv
// Combinational split of a 32-bit MIPS word into datapath fields.
// func is only meaningful for R-type words and reads as zero otherwise.
module ifd_field_split
  import ifd_pkg::*;
(
  input  logic [31:0]  instr,
  output ifd_fields_t  fields
);

  always_comb begin
    fields       = '0;
    fields.opc   = instr[OPC_MSB:OPC_LSB];
    fields.rs    = instr[RS_MSB:RS_LSB];
    fields.rt    = instr[RT_MSB:RT_LSB];
    fields.rd    = instr[RD_MSB:RD_LSB];
    fields.imm16 = instr[IMM_MSB:IMM_LSB];
    fields.func  = (instr[OPC_MSB:OPC_LSB] == OPC_RTYPE) ? instr[FUNC_MSB:FUNC_LSB] : 6'd0;
  end

endmodule

// File: rtl/ifetch_decode.sv
// Fetch/decode stage: REQ -> RESP -> HOLD loop with one-cycle PC redirect.
// Optional halt-on-opcode-111111 behaviour is enabled by IFD_HALT_EN.
module ifetch_decode
  import ifd_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_en,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [5:0]          opc,
  output logic [5:0]          func,
  output logic [4:0]          Number1,
  output logic [4:0]          Number2,
  output logic [4:0]          rd,
  output logic [15:0]         imm16,
  output logic [PC_WIDTH-1:0] pc_out,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                halted
);

  ifd_state_e          state;
  logic [PC_WIDTH-1:0] pc;
  ifd_fields_t         fld;
  ifd_fields_t         split;

  ifd_field_split u_split (
    .instr  (imem_rdata),
    .fields (split)
  );

`ifdef IFD_HALT_EN
  logic halt_q;
  assign halted = halt_q;
`else
  assign halted = 1'b0;
`endif

  // imem_en/imem_addr are loaded on the edge that enters REQ so every output stays registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      imem_en   <= 1'b0;
      imem_addr <= RESET_PC;
      out_valid <= 1'b0;
      fld       <= '0;
      pc_out    <= '0;
`ifdef IFD_HALT_EN
      halt_q    <= 1'b0;
`endif
    end else if (redirect_valid) begin
      state     <= S_REQ;
      pc        <= redirect_pc;
      imem_en   <= 1'b1;
      imem_addr <= redirect_pc;
      out_valid <= 1'b0;
`ifdef IFD_HALT_EN
      halt_q    <= 1'b0;
`endif
    end else begin
      imem_en <= 1'b0;
      case (state)
        S_IDLE: begin
          state     <= S_REQ;
          imem_en   <= 1'b1;
          imem_addr <= pc;
        end
        S_REQ: state <= S_RESP;
        S_RESP: begin
          fld       <= split;
          pc_out    <= pc;
          pc        <= pc + 1'b1;
          out_valid <= 1'b1;
`ifdef IFD_HALT_EN
          if (is_halt(split.opc)) begin
            state  <= S_HALT;
            halt_q <= 1'b1;
          end else begin
            state  <= S_HOLD;
          end
`else
          state     <= S_HOLD;
`endif
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_REQ;
            imem_en   <= 1'b1;
            imem_addr <= pc;
          end
        end
`ifdef IFD_HALT_EN
        // The halt word is still handed over, but nothing further is fetched.
        S_HALT: if (out_ready) out_valid <= 1'b0;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign opc     = fld.opc;
  assign func    = fld.func;
  assign Number1 = fld.rs;
  assign Number2 = fld.rt;
  assign rd      = fld.rd;
  assign imm16   = fld.imm16;

endmodule

// File: tb/tb_ifetch_decode.sv
// Bench for ifetch_decode: directed test-plan steps, then random traffic,
// all checked every cycle against a transaction-timed model.
module tb_ifetch_decode;
  localparam int PW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          imem_en;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [5:0]    opc, func;
  logic [4:0]    Number1, Number2, rd;
  logic [15:0]   imm16;
  logic [PW-1:0] pc_out;
  logic          redirect_valid = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic          halted;

  ifetch_decode #(.PC_WIDTH(PW), .RESET_PC('0)) dut (
    .clock(clock), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .opc(opc), .func(func), .Number1(Number1), .Number2(Number2), .rd(rd),
    .imm16(imm16), .pc_out(pc_out), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:255];
  // Synchronous memory; junk appears when no read is requested.
  always @(posedge clock) imem_rdata <= imem_en ? mem[imem_addr] : $urandom;

  int n_chk = 0, n_fail = 0, cyc = 0;

  // Model: times at which a fetch and a presentation are due, plus held values.
  int            req_at = -1, show_at = -1;
  bit            in_reset = 1'b1, presenting = 1'b0, m_halted = 1'b0, cur_halt = 1'b0;
  logic [PW-1:0] mpc = '0, fetch_addr = '0, show_pc = '0, m_pcout = '0;
  logic [31:0]   show_word = '0, m_word = '0;

  function automatic bit is_halt_word(input logic [31:0] w);
`ifdef IFD_HALT_EN
    return w[31:26] == 6'h3f;
`else
    return (w == 32'hffff_ffff) && (w != 32'hffff_ffff);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic advance(input bit rst, input bit rdv, input logic [PW-1:0] rpc, input bit rdy);
    int n;
    n = cyc + 1;
    if (rst) begin
      in_reset = 1'b1; req_at = -1; show_at = -1; presenting = 1'b0; m_halted = 1'b0;
      mpc = '0; fetch_addr = '0; m_word = '0; m_pcout = '0;
    end else begin
      if (in_reset) begin
        in_reset = 1'b0; req_at = n;
      end else if (rdv) begin
        presenting = 1'b0; show_at = -1; m_halted = 1'b0; mpc = rpc; req_at = n;
      end else begin
        if (presenting && rdy) begin
          presenting = 1'b0;
          if (!cur_halt) req_at = n;
        end
        if (show_at == n) begin
          presenting = 1'b1; m_word = show_word; m_pcout = show_pc;
          cur_halt = is_halt_word(show_word);
          if (cur_halt) m_halted = 1'b1;
        end
      end
      if (req_at == n) begin
        fetch_addr = mpc; show_word = mem[mpc]; show_pc = mpc; show_at = n + 2; mpc = mpc + 1'b1;
      end
    end
  endtask

  task automatic compare();
    logic [5:0] eo, ef;
    eo = m_word[31:26];
    ef = (eo == 6'd0) ? m_word[5:0] : 6'd0;
    chk("imem_en",   32'(imem_en),   32'(req_at == cyc));
    chk("imem_addr", 32'(imem_addr), 32'(fetch_addr));
    chk("out_valid", 32'(out_valid), 32'(presenting));
    chk("halted",    32'(halted),    32'(m_halted));
    chk("opc",       32'(opc),       32'(eo));
    chk("func",      32'(func),      32'(ef));
    chk("Number1",   32'(Number1),   32'(m_word[25:21]));
    chk("Number2",   32'(Number2),   32'(m_word[20:16]));
    chk("rd",        32'(rd),        32'(m_word[15:11]));
    chk("imm16",     32'(imm16),     32'(m_word[15:0]));
    chk("pc_out",    32'(pc_out),    32'(m_pcout));
  endtask

  task automatic cycle(input bit rst, input bit rdv, input logic [PW-1:0] rpc, input bit rdy);
    reset = rst; redirect_valid = rdv; redirect_pc = rpc; out_ready = rdy;
    advance(rst, rdv, rpc, rdy);
    @(posedge clock);
    @(negedge clock);
    cyc++;
    compare();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0]     = 32'h00011020;
    mem[1]     = 32'h2022000A;
    mem[2]     = 32'h01234567;
    mem[3]     = 32'hFC000000;
    mem[4]     = 32'h8C410004;
    mem[8'h40] = 32'h00432020;
    mem[8'hFF] = 32'h20420001;

    repeat (3) cycle(1, 0, '0, 0);
    chk("lit_rst_valid", 32'(out_valid), 32'd0);
    chk("lit_rst_addr",  32'(imem_addr), 32'd0);
    chk("lit_rst_opc",   32'(opc),       32'd0);

    // First R-type fetch
    cycle(0, 0, '0, 1);
    chk("lit_req0_en",   32'(imem_en),   32'd1);
    chk("lit_req0_addr", 32'(imem_addr), 32'd0);
    cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 1);
    chk("lit_r_valid", 32'(out_valid), 32'd1);
    chk("lit_r_opc",   32'(opc),       32'd0);
    chk("lit_r_rs",    32'(Number1),   32'd0);
    chk("lit_r_rt",    32'(Number2),   32'd1);
    chk("lit_r_rd",    32'(rd),        32'd2);
    chk("lit_r_func",  32'(func),      32'h20);
    chk("lit_r_pcout", 32'(pc_out),    32'd0);
    cycle(0, 0, '0, 1);
    chk("lit_req1_addr", 32'(imem_addr), 32'd1);

    // I-type, then stall for five cycles
    cycle(0, 0, '0, 0);
    cycle(0, 0, '0, 0);
    chk("lit_i_opc",  32'(opc),     32'h08);
    chk("lit_i_func", 32'(func),    32'd0);
    chk("lit_i_rs",   32'(Number1), 32'd1);
    chk("lit_i_rt",   32'(Number2), 32'd2);
    chk("lit_i_imm",  32'(imm16),   32'h000A);
    repeat (5) cycle(0, 0, '0, 0);
    chk("lit_stall_valid", 32'(out_valid), 32'd1);
    chk("lit_stall_en",    32'(imem_en),   32'd0);
    cycle(0, 0, '0, 1);
    chk("lit_req2_en",   32'(imem_en),   32'd1);
    chk("lit_req2_addr", 32'(imem_addr), 32'd2);

    // Redirect during RESP drops the returning word
    cycle(0, 0, '0, 0);
    cycle(0, 1, 8'h40, 0);
    chk("lit_redir_addr",  32'(imem_addr), 32'h40);
    chk("lit_redir_valid", 32'(out_valid), 32'd0);
    cycle(0, 0, '0, 0);
    chk("lit_redir_novalid", 32'(out_valid), 32'd0);
    cycle(0, 0, '0, 0);
    chk("lit_redir_pcout", 32'(pc_out), 32'h40);

    // PC wrap from FF
    cycle(0, 1, 8'hFF, 0);
    cycle(0, 0, '0, 0);
    cycle(0, 0, '0, 0);
    chk("lit_ff_pcout", 32'(pc_out), 32'hFF);
    cycle(0, 0, '0, 1);
    chk("lit_wrap_addr", 32'(imem_addr), 32'd0);

    // Reset in the middle of a fetch
    cycle(1, 0, '0, 0);
    chk("lit_midrst_valid", 32'(out_valid), 32'd0);
    chk("lit_midrst_en",    32'(imem_en),   32'd0);
    cycle(0, 0, '0, 0);
    chk("lit_after_rst_addr", 32'(imem_addr), 32'd0);
    cycle(0, 0, '0, 0);
    cycle(0, 0, '0, 1);

    // Halt opcode
    cycle(0, 1, 8'd3, 0);
    cycle(0, 0, '0, 0);
    cycle(0, 0, '0, 0);
    chk("lit_halt_opc", 32'(opc), 32'h3F);
`ifdef IFD_HALT_EN
    chk("lit_halted", 32'(halted), 32'd1);
`endif
    cycle(0, 0, '0, 1);
    repeat (10) cycle(0, 0, '0, 0);
`ifdef IFD_HALT_EN
    chk("lit_halt_en",   32'(imem_en), 32'd0);
    chk("lit_halt_stay", 32'(halted),  32'd1);
`endif
    cycle(0, 1, 8'd0, 0);
    chk("lit_resume_en",   32'(imem_en),   32'd1);
    chk("lit_resume_addr", 32'(imem_addr), 32'd0);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      bit r, d, y;
      r = ($urandom_range(0, 199) == 0);
      d = !r && !in_reset && ($urandom_range(0, 15) == 0);
      y = 1'($urandom_range(0, 1));
      cycle(r, d, PW'($urandom), y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
